// File: rtl/sdc_bus_if.sv
// sdc_bus_if: CoCo3 SD controller CPU bus decode, access strobes and HALT handshake.
// Ports: CLK/RESET (async, active-high); CPU_* bus inputs and E_FALL cycle marker;
// MPI_SCS_SLOT slot select; SDC_HALT_REQ/SDC_READ_DATA from the core; ADDRESS,
// SDC_DATA_IN, SDC_WR, SDC_RD, CLK_EN, SDC_EN to the core; CPU_DIN/CPU_DIN_EN read
// path; CPU_HALT_N, HALT_ACK, HALT_TO halt handshake. Optional HALT timeout is
// enabled by defining COCO3_SDC_HALT_TIMEOUT_EN.
module sdc_bus_if #(
  parameter logic [1:0]  SLOT         = 2'd3,
  parameter logic [19:0] HALT_TIMEOUT = 20'd1000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_RW,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        E_FALL,
  input  logic        CPU_BA,
  input  logic        CPU_BS,
  input  logic [1:0]  MPI_SCS_SLOT,
  input  logic        SDC_HALT_REQ,
  input  logic [7:0]  SDC_READ_DATA,
  output logic [3:0]  ADDRESS,
  output logic [7:0]  SDC_DATA_IN,
  output logic        SDC_WR,
  output logic        SDC_RD,
  output logic        CLK_EN,
  output logic        SDC_EN,
  output logic [7:0]  CPU_DIN,
  output logic        CPU_DIN_EN,
  output logic        CPU_HALT_N,
  output logic        HALT_ACK,
  output logic        HALT_TO
);
  typedef enum logic [1:0] {H_IDLE, H_ASSERT, H_HALTED, H_RELEASE} h_state_t;
  h_state_t r_state, w_next;
  logic w_sel, w_to_hit, w_block;
  assign w_sel      = (CPU_ADDR[15:4] == 12'hFF4) & ~CPU_BA;
  assign CPU_DIN    = SDC_READ_DATA;
  assign CPU_DIN_EN = w_sel & CPU_RW;
  assign CPU_HALT_N = ~(r_state == H_ASSERT || r_state == H_HALTED);
  assign HALT_ACK   = r_state == H_HALTED;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      ADDRESS     <= '0;
      SDC_DATA_IN <= '0;
      SDC_WR      <= 1'b0;
      SDC_RD      <= 1'b0;
      CLK_EN      <= 1'b0;
      SDC_EN      <= 1'b0;
      r_state     <= H_IDLE;
    end else begin
      ADDRESS     <= w_sel ? CPU_ADDR[3:0] : ADDRESS;
      SDC_DATA_IN <= w_sel ? CPU_DATA_OUT : SDC_DATA_IN;
      SDC_WR      <= E_FALL & w_sel & ~CPU_RW;
      SDC_RD      <= E_FALL & w_sel & CPU_RW;
      CLK_EN      <= E_FALL & w_sel;
      SDC_EN      <= MPI_SCS_SLOT == SLOT;
      r_state     <= w_next;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      H_IDLE:    w_next = (SDC_HALT_REQ & ~w_block) ? H_ASSERT : H_IDLE;
      H_ASSERT:  w_next = (~SDC_HALT_REQ | w_to_hit) ? H_RELEASE : (CPU_BA & CPU_BS) ? H_HALTED : H_ASSERT;
      H_HALTED:  w_next = (~SDC_HALT_REQ | w_to_hit) ? H_RELEASE : H_HALTED;
      H_RELEASE: w_next = H_IDLE;
      default:   w_next = H_IDLE;
    endcase
  end
`ifdef COCO3_SDC_HALT_TIMEOUT_EN
  logic [19:0] r_cnt;
  logic        r_block, r_to;
  // Counter is zero whenever the FSM is outside the halt states, so it starts
  // at zero on every entry to H_ASSERT.
  assign w_to_hit = (r_state == H_ASSERT || r_state == H_HALTED) && r_cnt == HALT_TIMEOUT - 20'd1;
  assign w_block  = r_block;
  assign HALT_TO  = r_to;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_cnt   <= '0;
      r_block <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_cnt   <= (r_state == H_ASSERT || r_state == H_HALTED) ? r_cnt + 20'd1 : '0;
      r_block <= w_to_hit | (r_block & SDC_HALT_REQ);
      r_to    <= r_to | w_to_hit;
    end
`else
  assign w_to_hit = 1'b0;
  assign w_block  = 1'b0;
  assign HALT_TO  = 1'b0;
`endif
endmodule
